// File: rtl/ahb_slave_protocol_checker.sv
// rtl/ahb_slave_protocol_checker.sv - AHB slave-side protocol checker with per-check pulses, sticky flags and wait stats
// Optional burst address checking is built when AHB_CHECKER_BURST_CHECK_EN is defined.
module ahb_slave_protocol_checker #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 16,
    parameter int CNT_WIDTH  = 8,
    parameter int WAIT_WIDTH = 8
) (
    input  logic                    hclk,
    input  logic                    hresetn,
    input  logic                    hselx,
    input  logic [ADDR_WIDTH-1:0]   haddr,
    input  logic [1:0]              htrans,
    input  logic                    hwrite,
    input  logic [2:0]              hsize,
    input  logic [2:0]              hburst,
    input  logic [3:0]              hprot,
    input  logic [DATA_WIDTH-1:0]   hwdata,
    input  logic [DATA_WIDTH/8-1:0] hwstrb,
    input  logic                    hreadyout,
    input  logic                    hresp,
    input  logic [DATA_WIDTH-1:0]   hrdata,
    input  logic                    hexokay,
    input  logic                    sticky_clr,
    output logic [4:0]              viol_pulse,
    output logic [4:0]              viol_sticky,
    output logic [CNT_WIDTH-1:0]    viol_count,
    output logic [WAIT_WIDTH-1:0]   max_wait
);

    typedef enum logic [1:0] {D_IDLE, D_DATA, D_ERR2, D_IDLDATA} dstate_t;

    dstate_t                 state;
    dstate_t                 state_nxt;
    logic                    apa;
    logic                    ia;
    logic                    phase_end;
    logic                    ctrl_live;
    logic [WAIT_WIDTH-1:0]   wait_cnt;
    logic [ADDR_WIDTH-1:0]   prev_addr;
    logic                    prev_write;
    logic [2:0]              prev_size;
    logic                    prev_valid;
    logic                    burst_viol;
    logic [4:0]              det;

    logic unused_ok;
    assign unused_ok = ^{hburst, hprot, hwdata, hwstrb, hrdata, hexokay};

    assign apa       = hselx & hreadyout & htrans[1];
    assign ia        = hselx & hreadyout & ~htrans[1];
    // A pending address is only meaningful while the current data phase is stalled
    assign ctrl_live = (state == D_DATA) & ~hreadyout & htrans[1];

    always_comb begin
        state_nxt = D_IDLE;
        phase_end = 1'b0;
        case (state)
            D_DATA: begin
                if (!hreadyout)
                    state_nxt = hresp ? D_ERR2 : D_DATA;
                else
                    phase_end = 1'b1;
            end
            D_ERR2, D_IDLDATA: phase_end = 1'b1;
            default: ;
        endcase
        if (phase_end || state == D_IDLE)
            state_nxt = apa ? D_DATA : (ia ? D_IDLDATA : D_IDLE);
    end

    always_comb begin
        det    = '0;
        det[0] = (state == D_DATA) & ~hreadyout & ~hresp & (wait_cnt == WAIT_WIDTH'(MAX_WAIT));
        det[1] = ((state == D_DATA) & hreadyout & hresp) |
                 ((state == D_ERR2) & ~(hreadyout & hresp));
        det[2] = (state == D_IDLDATA) & (~hreadyout | hresp);
        det[3] = ctrl_live & prev_valid &
                 ({haddr, hwrite, hsize} != {prev_addr, prev_write, prev_size});
        det[4] = burst_viol;
    end

`ifdef AHB_CHECKER_BURST_CHECK_EN
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [ADDR_WIDTH-1:0] beat_incr;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [ADDR_WIDTH-1:0] exp_addr;
    logic [2:0]            lat_size;
    logic [2:0]            lat_burst;
    logic                  lat_write;
    logic                  beat_valid;

    // Non-wrapping bursts use an all-ones mask so the same formula yields a plain increment
    always_comb begin
        beat_incr = ADDR_WIDTH'(1) << lat_size;
        case (lat_burst)
            3'd2:    wrap_mask = (beat_incr << 2) - ADDR_WIDTH'(1);
            3'd4:    wrap_mask = (beat_incr << 3) - ADDR_WIDTH'(1);
            3'd6:    wrap_mask = (beat_incr << 4) - ADDR_WIDTH'(1);
            default: wrap_mask = '1;
        endcase
        exp_addr = (lat_addr & ~wrap_mask) | ((lat_addr + beat_incr) & wrap_mask);
    end

    assign burst_viol = apa & (htrans == 2'b11) &
                        (~beat_valid | (haddr != exp_addr) |
                         (hsize != lat_size) | (hwrite != lat_write));

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            lat_addr   <= '0;
            lat_size   <= '0;
            lat_burst  <= '0;
            lat_write  <= 1'b0;
            beat_valid <= 1'b0;
        end else if (apa) begin
            lat_addr   <= haddr;
            lat_size   <= hsize;
            lat_burst  <= hburst;
            lat_write  <= hwrite;
            beat_valid <= 1'b1;
        end else if (ia && htrans == 2'b00) begin
            beat_valid <= 1'b0;
        end
    end
`else
    assign burst_viol = 1'b0;
`endif

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state       <= D_IDLE;
            wait_cnt    <= '0;
            prev_addr   <= '0;
            prev_write  <= 1'b0;
            prev_size   <= '0;
            prev_valid  <= 1'b0;
            viol_pulse  <= '0;
            viol_sticky <= '0;
            viol_count  <= '0;
            max_wait    <= '0;
        end else begin
            state <= state_nxt;

            // First ERROR cycle is not an OKAY wait, so the count holds there
            if (state == D_DATA && !hreadyout) begin
                if (!hresp && wait_cnt != '1)
                    wait_cnt <= wait_cnt + WAIT_WIDTH'(1);
            end else begin
                wait_cnt <= '0;
            end

            prev_valid <= ctrl_live;
            prev_addr  <= haddr;
            prev_write <= hwrite;
            prev_size  <= hsize;

            viol_pulse  <= det;
            viol_sticky <= sticky_clr ? det : (viol_sticky | det);

            if (sticky_clr)
                viol_count <= CNT_WIDTH'(|det);
            else if (|det && viol_count != '1)
                viol_count <= viol_count + CNT_WIDTH'(1);

            if (sticky_clr)
                max_wait <= phase_end ? wait_cnt : '0;
            else if (phase_end && wait_cnt > max_wait)
                max_wait <= wait_cnt;
        end
    end

endmodule
